// File: rtl/cpu_pkg.sv
// Shared CPU datapath types: default register geometry and register index type.
// Constant-only package; no logic, latency or flow control.
package cpu_pkg;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 3;

    typedef logic [DEF_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t ZERO_IDX = '0;
endpackage

// File: rtl/reg_file_rd_port.sv
// One register file read port: zero-register, writeback bypass and busy resolution.
// Purely combinational (zero latency); no backpressure, output forced to 0/not-busy during reset.
module reg_file_rd_port
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              reg_pending,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic is_zero;
    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_IDX));

    // A same-cycle writeback to this index is the freshest value and clears busy.
    always_comb begin
        data = '0;
        busy = 1'b0;
        if (!reset && !is_zero) begin
            if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
            end else begin
                data = reg_data;
                busy = reg_pending;
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-to-read bypass and pending-write scoreboard.
// Reads combinational, writes/reservations land on the next edge; never stalls (no backpressure).
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [2**ADDR_W-1:0]     pending,
    output logic                     rsv_err
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              wr_ok;
    logic              rsv_ok;
    logic              rsv_hit;

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == ADDR_W'(ZERO_IDX)));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_W'(ZERO_IDX)));

    // A writeback to the same index retires the old reservation, so re-reserving it is legal.
    assign rsv_hit = rsv_ok && pend[rsv_addr] && !(wr_ok && (wr_addr == rsv_addr));

    // Reservation is applied after the clear so a same-cycle issue keeps the bit set.
    always_comb begin
        pend_nxt = pend;
        if (wr_ok) begin
            pend_nxt[wr_addr] = 1'b0;
        end
        if (rsv_ok) begin
            pend_nxt[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pend    <= '0;
            rsv_err <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
            end
            pend    <= pend_nxt;
            rsv_err <= rsv_hit;
        end
    end

    assign pending = pend;

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        assign addr = rd_addr[p*ADDR_W +: ADDR_W];

        reg_file_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG)
        ) u_rd_port (
            .reset      (reset),
            .addr       (addr),
            .wr_en      (wr_en),
            .wr_addr    (wr_addr),
            .wr_data    (wr_data),
            .reg_data   (regs[addr]),
            .reg_pending(pend[addr]),
            .data       (rd_data[p*DATA_W +: DATA_W]),
            .busy       (rd_busy[p])
        );
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised, clocked multi-port register file with write-to-read bypass and a per-register pending-write scoreboard. Sits between decode/issue and writeback in the CPU datapath. Supplies operand values and busy flags to the issue stage so hazards stall instead of reading stale data. Replaces the single-width, combinationally written 8x16 register array.

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 3, register index width; DEPTH = 2**ADDR_W
NUM_RD, 2, number of independent read ports
ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never reserved

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  reset, synchronous, active-high
wr_en  in  1  writeback strobe
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback value
rsv_en  in  1  issue strobe: mark rsv_addr as pending
rsv_addr  in  ADDR_W  destination being reserved
rd_addr  in  NUM_RD*ADDR_W  read indices, port p at bits [p*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read values, same packing
rd_busy  out  NUM_RD  1 = port p operand not yet available
pending  out  2**ADDR_W  raw scoreboard bits, bit i = register i pending
rsv_err  out  1  registered pulse: reservation hit an already-pending register

Behaviour:
- Reset: on a rising edge with reset=1, all registers clear to 0, pending clears to 0, and rsv_err clears to 0. Writes and reservations in that cycle are ignored.
- While reset=1, rd_data=0 and rd_busy=0 combinationally.
- Write: on a rising edge with wr_en=1, array[wr_addr] <= wr_data and pending[wr_addr] <= 0. Exception: ZERO_REG=1 and wr_addr=0 makes the write a no-op.
- Read: combinational, zero latency, for each port p.
  - ZERO_REG=1 and addr=0 -> rd_data=0, rd_busy=0.
  - Otherwise, if wr_en=1 and wr_addr==addr -> rd_data=wr_data (bypass), rd_busy=0.
  - Otherwise, rd_data=array[addr] and rd_busy=pending[addr].
- Reserve: on a rising edge with rsv_en=1, pending[rsv_addr] <= 1. Ignored when ZERO_REG=1 and rsv_addr=0.
- Simultaneous wr_en and rsv_en to the same address: the write lands and the bypass applies this cycle. Pending ends SET because the new reservation wins over the clear.
- Simultaneous to different addresses: both take effect independently.
- rsv_err: registered, 1-cycle pulse. Asserted the cycle after rsv_en=1 targets a register with pending=1 that is not being cleared by a same-cycle write. Reservation still proceeds (bit stays 1).
- Write to a non-pending register is legal: data updates, pending stays 0, no error.
- Reset mid-operation discards all pending reservations; there is no replay.
- Any number of read ports may alias the same address; each port resolves independently and identically.
- No X propagation: the array is fully initialised by reset. Reads of unreset state before the first reset are undefined and not checked.

Decomposition:
- Shared package cpu_pkg: DATA_W/ADDR_W defaults, a reg_idx_t typedef, and the ZERO_IDX constant.
- One sub-module, reg_file_rd_port: pure combinational bypass/zero/busy mux for one port. Instantiated NUM_RD times in a generate loop.
- Storage array, scoreboard and rsv_err logic stay in the top.

Test Plan:
- Reset then read: hold reset 1 cycle; read ports 0..7 -> rd_data=0x0000, rd_busy=0, pending=0x00.
- Write then read: write 0xBEEF to r3; next cycle rd_addr p0=3 -> 0xBEEF. In the same cycle as the write, p1=3 -> 0xBEEF via bypass.
- Zero register: write 0x1234 to r0 and rsv r0 -> p0 reads 0x0000, pending[0]=0, rsv_err=0.
- Scoreboard:
  - rsv r5 -> next cycle rd_busy=1 on a port reading r5, pending=0x20.
  - wr r5=0x00AA -> same cycle busy=0 and data 0x00AA; next cycle pending=0x00.
- Collision: same cycle rsv r2 and wr r2=0x0042 -> that cycle reads 0x0042; next cycle pending[2]=1, busy=1, data 0x0042.
- Double reserve: rsv r4 twice on consecutive cycles -> rsv_err=1 for exactly one cycle after the second reservation. Then assert reset with r4 pending -> pending=0 and rsv_err=0 after the edge.
